// File: rtl/mem_dbus_bridge.sv
// Serialises 32-bit MEM-stage data accesses into byte transactions on an 8-bit req/ack bus.
// Optional BUS_TIMEOUT_EN adds a per-byte ack timeout with a sticky err_o flag.
module mem_dbus_bridge #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_wdata_o,
  input  logic [7:0]        bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_e;

  if (ADDR_W < 3 || ADDR_W > 32) begin : g_bad_addr_w
    $error("mem_dbus_bridge: ADDR_W must lie in 3..32");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("mem_dbus_bridge: TIMEOUT_CYC must lie in 1..255");
  end

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_req_q, bus_req_d;
  logic [2:0]  nxt_lane;
  logic        lane_fin;
  logic        tmo_fire;
  logic        unused_bits;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  // Abandon on the edge at which the wait count would reach TIMEOUT_CYC.
  assign tmo_fire = (state_q == ST_XFER) && !bus_ack_i && (wait_q == TMO_LAST);
  assign err_o    = err_q;
`else
  assign tmo_fire = 1'b0;
  assign err_o    = 1'b0;
`endif

  // Lowest lane a new access starts on: lane 0 for reads, lowest enabled lane for writes.
  function automatic logic [1:0] first_lane(input logic is_wr, input logic [3:0] sel);
    logic [1:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && (!is_wr || sel[k])) begin
        r     = k[1:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // {valid, lane}: next lane above cur that still needs servicing.
  function automatic logic [2:0] next_lane(input logic is_wr, input logic [3:0] sel,
                                           input logic [1:0] cur);
    logic [2:0] r;
    r = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!r[2] && (k > 32'(cur)) && (!is_wr || sel[k])) begin
        r = {1'b1, k[1:0]};
      end
    end
    return r;
  endfunction

  assign lane_fin    = (state_q == ST_XFER) && (bus_ack_i || tmo_fire);
  assign nxt_lane    = next_lane(we_q, sel_q, lane_q);

  assign mem_data_o  = rdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_req_q & we_q;
  assign bus_addr_o  = {addr_q[ADDR_W-3:0], lane_q};
  assign bus_wdata_o = wdata_q[{lane_q, 3'b000} +: 8];
  assign stallreq_o  = (state_q == ST_IDLE) ? mem_ce_i : (state_q == ST_XFER);
  assign unused_bits = ^{mem_addr_i[1:0], addr_q};

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef BUS_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          we_d    = mem_we_i;
          addr_d  = mem_addr_i[31:2];
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          lane_d  = first_lane(mem_we_i, mem_sel_i);
`ifdef BUS_TIMEOUT_EN
          wait_d  = '0;
`endif
          if (mem_we_i && (mem_sel_i == 4'b0000)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_XFER;
          end
        end
      end

      ST_XFER: begin
        if (lane_fin) begin
          if (!we_q) begin
            rdata_d[{lane_q, 3'b000} +: 8] = bus_ack_i ? bus_rdata_i : 8'h00;
          end
          if (nxt_lane[2]) begin
            lane_d = nxt_lane[1:0];
          end else begin
            state_d = ST_DONE;
          end
        end
`ifdef BUS_TIMEOUT_EN
        if (tmo_fire) begin
          err_d = 1'b1;
        end
        wait_d = lane_fin ? 8'h00 : wait_q + 8'h01;
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bus_req_d = (state_d == ST_XFER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_req_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_req_q <= bus_req_d;
`ifdef BUS_TIMEOUT_EN
      wait_q    <= wait_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_dbus_bridge.sv
// Self-checking bench for mem_dbus_bridge: directed scenarios plus randomized accesses
// checked against a per-access transaction model.
module tb_mem_dbus_bridge;

  localparam int unsigned TB_AW  = 20;
  localparam int          TB_TMO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_ce_i, mem_we_i;
  logic [31:0]       mem_addr_i, mem_data_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_o;
  logic              stallreq_o, bus_req_o, bus_we_o, err_o;
  logic [TB_AW-1:0]  bus_addr_o;
  logic [7:0]        bus_wdata_o, bus_rdata_i;
  logic              bus_ack_i;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [31:0] exp_word = '0;
  logic        exp_err  = 1'b0;

  mem_dbus_bridge #(
    .ADDR_W      (TB_AW),
    .TIMEOUT_CYC (TB_TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sel_i   (mem_sel_i),
    .mem_data_i  (mem_data_i),
    .mem_data_o  (mem_data_o),
    .stallreq_o  (stallreq_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full access from the IDLE cycle through DONE; read bytes come from rd_word.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] data, input logic [31:0] rd_word,
                            input int fixed_wait, input logic hold_ce, input logic [3:0] noack);
    int          lanes[$];
    int          cyc, stall_seen, exp_stall;
    logic        tmo;
    logic [31:0] exp_addr, amask;
    amask = (32'd1 << TB_AW) - 32'd1;
    for (int k = 0; k < 4; k++) if (!we || sel[k]) lanes.push_back(k);

    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = data;
    bus_ack_i = 1'b0; bus_rdata_i = 8'($urandom);
    @(negedge clk);
    check("idle_stall", {31'b0, stallreq_o}, 32'd1);
    check("idle_req", {31'b0, bus_req_o}, 32'd0);
    stall_seen = int'(stallreq_o);
    exp_stall  = 1;
    next_cycle();

    foreach (lanes[i]) begin
      tmo = noack[lanes[i]];
      cyc = tmo ? TB_TMO : ((fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2))) + 1;
      exp_stall += cyc;
      exp_addr = ((addr & 32'hFFFF_FFFC) | 32'(lanes[i])) & amask;
      for (int j = 0; j < cyc; j++) begin
        mem_ce_i = 1'($urandom); mem_we_i = 1'($urandom); mem_sel_i = 4'($urandom);
        mem_addr_i = $urandom; mem_data_i = $urandom;
        bus_ack_i = !tmo && (j == cyc - 1);
        bus_rdata_i = bus_ack_i ? rd_word[8*lanes[i] +: 8] : 8'($urandom);
        @(negedge clk);
        check("xfer_req", {31'b0, bus_req_o}, 32'd1);
        check("xfer_we", {31'b0, bus_we_o}, {31'b0, we});
        check("xfer_addr", {{(32-TB_AW){1'b0}}, bus_addr_o}, exp_addr);
        check("xfer_wdata", {24'b0, bus_wdata_o}, {24'b0, data[8*lanes[i] +: 8]});
        check("xfer_rdata_hold", mem_data_o, exp_word);
        stall_seen += int'(stallreq_o);
        next_cycle();
      end
      if (!we) exp_word[8*lanes[i] +: 8] = tmo ? 8'h00 : rd_word[8*lanes[i] +: 8];
      if (tmo) exp_err = 1'b1;
    end

    mem_ce_i = hold_ce; bus_ack_i = 1'($urandom); bus_rdata_i = 8'($urandom);
    @(negedge clk);
    check("done_stall", {31'b0, stallreq_o}, 32'd0);
    check("done_req", {31'b0, bus_req_o}, 32'd0);
    check("done_data", mem_data_o, exp_word);
    check("done_err", {31'b0, err_o}, {31'b0, exp_err});
    check("stall_cycles", 32'(stall_seen), 32'(exp_stall));
    next_cycle();
    bus_ack_i = 1'b0;
    if (!hold_ce) begin
      mem_ce_i = 1'b0;
      @(negedge clk);
      check("idle_gap_stall", {31'b0, stallreq_o}, 32'd0);
      check("idle_gap_data", mem_data_o, exp_word);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    mem_data_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_req", {31'b0, bus_req_o}, 32'd0);
    check("rst_we", {31'b0, bus_we_o}, 32'd0);
    check("rst_stall", {31'b0, stallreq_o}, 32'd0);
    check("rst_data", mem_data_o, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_addr", {{(32-TB_AW){1'b0}}, bus_addr_o}, 32'd0);
    next_cycle();
    rst = 1'b1;

    run_access(1'b0, 32'h0000_0104, 4'b0000, 32'h0, 32'h4433_2211, 0, 1'b0, 4'b0000);
    check("read_word", mem_data_o, 32'h4433_2211);
    run_access(1'b1, 32'h0000_0208, 4'b1010, 32'hAABB_CCDD, 32'h0, 2, 1'b0, 4'b0000);
    check("write_keeps_data", mem_data_o, 32'h4433_2211);
    run_access(1'b1, 32'h0000_0300, 4'b0000, 32'h1234_5678, 32'h0, 0, 1'b0, 4'b0000);

    run_access(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 4'b0000);
    run_access(1'b0, 32'h0000_0020, 4'b0000, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 4'b0000);

    for (int n = 0; n < 40; n++) begin
      run_access(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom, -1,
                 1'($urandom), 4'b0000);
    end

    // Reset while lane 2 of a read is still pending.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0400; mem_sel_i = '0;
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      mem_ce_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 8'(8'h5A + k);
      next_cycle();
    end
    bus_ack_i = 1'b0;
    @(negedge clk);
    check("pre_rst_lane2_req", {31'b0, bus_req_o}, 32'd1);
    check("pre_rst_low_bytes", {16'b0, mem_data_o[15:0]}, 32'h0000_5B5A);
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req", {31'b0, bus_req_o}, 32'd0);
    check("mid_rst_stall", {31'b0, stallreq_o}, 32'd0);
    check("mid_rst_data", mem_data_o, 32'd0);
    exp_word = '0;
    exp_err  = 1'b0;
    next_cycle();
    run_access(1'b0, 32'h0000_0500, 4'b0000, 32'h0, 32'h0102_0304, 0, 1'b0, 4'b0000);

`ifdef BUS_TIMEOUT_EN
    run_access(1'b0, 32'h0000_0600, 4'b0000, 32'h0, 32'h8877_6655, 0, 1'b0, 4'b0010);
    check("tmo_byte1", {24'b0, mem_data_o[15:8]}, 32'd0);
    check("tmo_err_set", {31'b0, err_o}, 32'd1);
    run_access(1'b1, 32'h0000_0700, 4'b0110, 32'h1122_3344, 32'h0, 1, 1'b0, 4'b0000);
    check("tmo_err_sticky", {31'b0, err_o}, 32'd1);
`endif

    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("final_rst_err", {31'b0, err_o}, 32'd0);
    check("final_rst_data", mem_data_o, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
